// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and special instruction words.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] PC_INC     = 32'd4;

endpackage

// File: rtl/imem_dist.sv
// Word-addressed instruction memory: synchronous write port, asynchronous read port.
module imem_dist #(
  parameter int NB_INSTR = 32,
  parameter int NB_ADDR  = 8
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [NB_ADDR-1:0]  i_waddr,
  input  logic [NB_INSTR-1:0] i_wdata,
  input  logic [NB_ADDR-1:0]  i_raddr,
  output logic [NB_INSTR-1:0] o_rdata
);

  logic [NB_INSTR-1:0] r_mem [2**NB_ADDR];

  // Contents are loaded by the debug unit and deliberately survive reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, debug-loaded instruction memory and run/step/halt FSM.
// Optional fetch counter output o_fetch_cnt is enabled by defining IFETCH_FETCH_CNT_EN.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                NB_INSTR = 32,
  parameter int                NB_PC    = 32,
  parameter int                NB_ADDR  = 8,
  parameter logic [NB_PC-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_mode_step,
  input  logic                i_step,
  input  logic                i_stall,
  input  logic                i_redirect,
  input  logic [NB_PC-1:0]    i_redirect_pc,
  input  logic                i_load_we,
  input  logic [NB_ADDR-1:0]  i_load_addr,
  input  logic [NB_INSTR-1:0] i_load_data,
  output logic [NB_INSTR-1:0] o_instr,
  output logic [NB_PC-1:0]    o_pc,
  output logic [NB_PC-1:0]    o_pc_next,
  output logic                o_valid,
  output logic                o_halted,
  output logic [1:0]          o_state
`ifdef IFETCH_FETCH_CNT_EN
  ,
  output logic [31:0]         o_fetch_cnt
`endif
);

  fetch_state_e        r_state;
  fetch_state_e        w_state_next;
  logic [NB_PC-1:0]    r_pc;
  logic [NB_PC-1:0]    w_pc_next;
  logic                r_step_pending;
  logic                w_step_pending_next;
  logic [NB_INSTR-1:0] w_mem_word;
  logic                w_active;
  logic                w_is_halt;
  logic                w_fetch;
  logic                w_load_en;

  assign w_load_en = i_load_we && (r_state == ST_IDLE);

  imem_dist #(
    .NB_INSTR (NB_INSTR),
    .NB_ADDR  (NB_ADDR)
  ) u_imem (
    .clk     (clk),
    .i_we    (w_load_en),
    .i_waddr (i_load_addr),
    .i_wdata (i_load_data),
    .i_raddr (r_pc[NB_ADDR+1:2]),
    .o_rdata (w_mem_word)
  );

  assign w_active  = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign w_is_halt = w_active && (w_mem_word == NB_INSTR'(HALT_INSTR));

  // A redirect or a HALT word at PC always suppresses the fetch.
  always_comb begin
    w_fetch = 1'b0;
    case (r_state)
      ST_RUN:  w_fetch = !i_stall;
      ST_STEP: w_fetch = r_step_pending && !i_stall;
      default: w_fetch = 1'b0;
    endcase
    if (i_redirect || w_is_halt) begin
      w_fetch = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_pc           <= RESET_PC;
      r_step_pending <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_pc           <= w_pc_next;
      r_step_pending <= w_step_pending_next;
    end
  end

  // A step pulse arriving while one is pending merges into that pending step.
  always_comb begin
    w_state_next        = r_state;
    w_pc_next           = r_pc;
    w_step_pending_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next = i_mode_step ? ST_STEP : ST_RUN;
        end
      end
      ST_RUN, ST_STEP: begin
        if (i_redirect) begin
          w_pc_next = i_redirect_pc & ~NB_PC'(3);
        end else if (w_is_halt) begin
          w_state_next = ST_HALT;
        end else if (w_fetch) begin
          w_pc_next = r_pc + NB_PC'(PC_INC);
        end
        if (r_state == ST_STEP) begin
          w_step_pending_next = r_step_pending ? !w_fetch : i_step;
        end
      end
      default: begin
        w_state_next = r_state;
      end
    endcase
  end

  always_comb begin
    o_valid  = w_fetch;
    o_instr  = w_fetch ? w_mem_word : NB_INSTR'(NOP_INSTR);
    o_halted = (r_state == ST_HALT);
    o_state  = r_state;
  end

  assign o_pc      = r_pc;
  assign o_pc_next = r_pc + NB_PC'(PC_INC);

`ifdef IFETCH_FETCH_CNT_EN
  logic [31:0] r_fetch_cnt;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_fetch_cnt <= '0;
    end else if (w_fetch) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
`endif

endmodule
